uart_rx: RTL

- Serial receive stage of the UART: oversamples the Rx line at 16x the baud rate, deserialises 8N1 frames and delivers each byte with a one-cycle done strobe.
- Sits directly upstream of the APB UART register block. Its RxData and RxDone outputs feed that block's RxDbuffer load path, and its RxStopBit output feeds the FE status bit.
- The baud divisor and enable come from the register block's UBRR/ControlReg fields.

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver. Drives the register block's receive
// buffer load path (RxData/RxDone) and its framing-error flag (RxStopBit).
`timescale 1ns/1ps

module uart_rx #(
    parameter int DIV_W = 12,
    parameter int OSR   = 16
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic             RxEn,
    input  logic [DIV_W-1:0] BaudDiv,
    input  logic             Rx,
    output logic [7:0]       RxData,
    output logic             RxDone,
    output logic             RxStopBit,
    output logic             RxBusy
);

    localparam int OS_W = $clog2(OSR);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0] OS_SAMP0 = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0] OS_SAMP1 = OS_W'(OSR / 2);
    localparam logic [OS_W-1:0] OS_DECIDE = OS_W'(OSR / 2 + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e             state_q, state_d;
    logic               rx_meta_q, rx_s_q, rx_d_q;
    logic [DIV_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]         samp_q, samp_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               done_q, done_d;
    logic               stop_err_q, stop_err_d;

    logic               tick;
    logic [OS_W-1:0]    os_next;
    logic               decide;
    logic               wrap;
    logic               majority;
    logic               start_det;

    // The decision tick is the one that moves os_cnt onto OS_DECIDE, so the
    // start-bit decision lands 9 ticks after the start-detect reference.
    assign tick      = (baud_cnt_q == '0);
    assign os_next   = os_cnt_q + 1'b1;
    assign decide    = tick && (os_next == OS_DECIDE);
    assign wrap      = tick && (os_cnt_q == OS_LAST);
    assign majority  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign start_det = RxEn && (state_q == IDLE) && !rx_s_q && rx_d_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no
        // path through the case below can infer a latch.
        state_d    = state_q;
        baud_cnt_d = tick ? BaudDiv : baud_cnt_q - 1'b1;
        os_cnt_d   = tick ? os_next : os_cnt_q;
        samp_d     = samp_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        stop_err_d = stop_err_q;
        done_d     = 1'b0;

        if (tick && (os_next == OS_SAMP0)) samp_d[0] = rx_s_q;
        if (tick && (os_next == OS_SAMP1)) samp_d[1] = rx_s_q;

        if (state_q != IDLE && !RxEn) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_det) begin
                        state_d    = START;
                        baud_cnt_d = BaudDiv;
                        os_cnt_d   = '0;
                        bit_cnt_d  = '0;
                    end
                end
                START: begin
                    if (decide && majority) state_d = IDLE;
                    else if (wrap)          state_d = DATA;
                end
                DATA: begin
                    if (decide) begin
                        shreg_d   = {majority, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (wrap && bit_cnt_q == 4'd8) state_d = STOP;
                end
                STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is caught.
                    if (decide) begin
                        rx_data_d  = shreg_q;
                        stop_err_d = ~majority;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            // NOTE: synchroniser flops reset to the idle line level so that
            // reset release cannot look like a start edge.
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_d_q     <= 1'b1;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            rx_meta_q  <= Rx;
            rx_s_q     <= rx_meta_q;
            rx_d_q     <= rx_s_q;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            stop_err_q <= stop_err_d;
        end
    end

    assign RxData    = rx_data_q;
    assign RxDone    = done_q;
    assign RxStopBit = stop_err_q;
    assign RxBusy    = (state_q != IDLE);

endmodule
